// File: rtl/bgsub_frame_reader.sv
// Frame reader for background subtraction: sweeps both frame memories in lockstep and streams pixel pairs.
// Define BGSUB_DECIMATE_EN for a half-resolution sweep (even columns of even lines only).
module bgsub_frame_reader #(
  parameter int FRAME_W = 160,
  parameter int FRAME_H = 120,
  parameter int ADDR_W  = 15,
  parameter int MEM_LAT = 1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [4:0]        cur_data,
  input  logic [4:0]        ref_data,
  output logic [4:0]        current_frame,
  output logic [4:0]        reference_frame,
  output logic              acc_en,
  input  logic              acc_ready,
  output logic              line_end,
  output logic              frame_end,
  output logic              busy,
  output logic              frame_done
);

`ifdef BGSUB_DECIMATE_EN
  localparam int STEP_I      = 2;
  localparam int LAST_I      = (FRAME_H - 2) * FRAME_W + FRAME_W - 2;
  localparam int WRAP_I      = FRAME_W + 2;
`else
  localparam int STEP_I      = 1;
  localparam int LAST_I      = FRAME_W * FRAME_H - 1;
  localparam int WRAP_I      = 1;
`endif
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(STEP_I);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(FRAME_W - STEP_I);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_I);
  localparam logic [ADDR_W-1:0] WRAP_INC  = ADDR_W'(WRAP_I);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]  col;
  logic [MEM_LAT-1:0] pipe_v, pipe_le, pipe_fe;
  logic [11:0]        fifo_mem [4];
  logic [11:0]        head;
  logic [1:0]         wr_ptr, rd_ptr;
  logic [2:0]         count, inflight;
  logic               push, pop, tag_le, tag_fe, credit;

  assign tag_le   = (col == COL_LAST);
  assign tag_fe   = (rd_addr == LAST_ADDR);
  assign inflight = 3'($countones(pipe_v));
  assign push     = pipe_v[MEM_LAT-1];
  assign acc_en   = (count != 3'd0);
  assign pop      = acc_en && acc_ready;
  // Occupancy after this cycle's pop must leave room for every read still in the memory pipe.
  assign credit   = ({1'b0, count} + {1'b0, inflight} - {3'b0, pop}) < 4'd4;

  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        busy  = 1'b1;
        rd_en = credit;
        if (rd_en && tag_fe) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (inflight == 3'd0 && (count == 3'd0 || (count == 3'd1 && pop))) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      rd_addr <= '0;
      col     <= '0;
    end else if (state == IDLE && start) begin
      rd_addr <= '0;
      col     <= '0;
    end else if (rd_en && !tag_fe) begin
      if (tag_le) begin
        col     <= '0;
        rd_addr <= rd_addr + WRAP_INC;
      end else begin
        col     <= col + COL_STEP;
        rd_addr <= rd_addr + COL_STEP;
      end
    end
  end

  // Tags travel beside the read so they line up with the returning data.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pipe_v  <= '0;
      pipe_le <= '0;
      pipe_fe <= '0;
    end else begin
      pipe_v  <= MEM_LAT'({pipe_v, rd_en});
      pipe_le <= MEM_LAT'({pipe_le, rd_en && tag_le});
      pipe_fe <= MEM_LAT'({pipe_fe, rd_en && tag_fe});
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {cur_data, ref_data, pipe_le[MEM_LAT-1], pipe_fe[MEM_LAT-1]};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign head            = fifo_mem[rd_ptr];
  assign current_frame   = acc_en ? head[11:7] : '0;
  assign reference_frame = acc_en ? head[6:2]  : '0;
  assign line_end        = acc_en && head[1];
  assign frame_end       = acc_en && head[0];

endmodule

// File: tb/tb_bgsub_frame_reader.sv
// Scoreboard bench: two readers (MEM_LAT 1 and 2) share stimulus; a negedge monitor pops expected pairs.
module tb_bgsub_frame_reader;
  localparam int FW = 4;
`ifdef BGSUB_DECIMATE_EN
  localparam int FH = 4;
  localparam int STEP = 2;
`else
  localparam int FH = 2;
  localparam int STEP = 1;
`endif
  localparam int N  = (FW / STEP) * (FH / STEP);
  localparam int AW = 15;

  logic pclk = 1'b0, reset = 1'b0, start = 1'b0, acc_ready = 1'b1;
  always #5 pclk = ~pclk;

  logic [AW-1:0] rd_addr [2];
  logic [4:0]    cur_o [2], ref_o [2];
  logic          rd_en [2], acc_en [2], line_end [2], frame_end [2], busy [2], frame_done [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [4:0]    cd, rdt;
    logic [AW-1:0] s1;
    bgsub_frame_reader #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .MEM_LAT(g + 1)) dut (
      .pclk(pclk), .reset(reset), .start(start), .rd_addr(rd_addr[g]), .rd_en(rd_en[g]),
      .cur_data(cd), .ref_data(rdt), .current_frame(cur_o[g]), .reference_frame(ref_o[g]),
      .acc_en(acc_en[g]), .acc_ready(acc_ready), .line_end(line_end[g]), .frame_end(frame_end[g]),
      .busy(busy[g]), .frame_done(frame_done[g]));
    // memory model: cur = addr, ref = 31 - addr, latency g+1
    always @(posedge pclk) begin
      s1  <= rd_addr[g];
      cd  <= (g == 0) ? rd_addr[g][4:0] : s1[4:0];
      rdt <= 5'd31 - ((g == 0) ? rd_addr[g][4:0] : s1[4:0]);
    end
  end

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  logic [11:0] q0[$], q1[$];
  int xfers [2], done_cnt [2], first_acc [2], last_xfer [2], done_rel [2], issued [2], max_out [2];
  bit stalled [2];
  logic [11:0] held [2];

  always @(posedge pclk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    int rel;
    logic [11:0] outv, e;
    rel = cyc - start_cyc;
    for (int g = 0; g < 2; g++) begin
      outv = {cur_o[g], ref_o[g], line_end[g], frame_end[g]};
      if (rd_en[g]) issued[g]++;
      if (acc_en[g] && acc_ready) xfers[g]++;
      if (issued[g] - xfers[g] > max_out[g]) max_out[g] = issued[g] - xfers[g];
      if (rel == 1 && reset) chk($sformatf("first_issue%0d", g), {busy[g], rd_en[g], rd_addr[g]}, {2'b11, 15'd0});
      if (stalled[g]) chk($sformatf("stall_stable%0d", g), {acc_en[g], outv}, {1'b1, held[g]});
      stalled[g] = acc_en[g] && !acc_ready;
      held[g] = outv;
      if (acc_en[g] && first_acc[g] < 0) first_acc[g] = rel;
      if (acc_en[g] && acc_ready) begin
        last_xfer[g] = rel;
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_pair%0d", g), outv, 0);
          if (outv == 0) chk($sformatf("unexpected_pair%0d", g), 1, 0);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("pair%0d", g), outv, e);
        end
      end
      if (frame_done[g]) begin
        done_cnt[g]++;
        done_rel[g] = rel;
        chk($sformatf("busy_at_done%0d", g), busy[g], 0);
      end
    end
  end

  task automatic push_expected();
    logic [4:0] av;
    for (int l = 0; l < FH; l += STEP)
      for (int c = 0; c < FW; c += STEP) begin
        av = 5'(l * FW + c);
        q0.push_back({av, 5'd31 - av, 1'(c == FW - STEP), 1'(l == FH - STEP && c == FW - STEP)});
        q1.push_back({av, 5'd31 - av, 1'(c == FW - STEP), 1'(l == FH - STEP && c == FW - STEP)});
      end
  endtask

  task automatic check_all_zero(input string nm);
    for (int g = 0; g < 2; g++)
      chk($sformatf("%s%0d", nm, g), {rd_addr[g], rd_en[g], cur_o[g], ref_o[g], acc_en[g], line_end[g],
          frame_end[g], busy[g], frame_done[g]}, 0);
  endtask

  task automatic begin_frame();
    for (int g = 0; g < 2; g++) begin
      xfers[g] = 0; done_cnt[g] = 0; first_acc[g] = -1; last_xfer[g] = -1;
      done_rel[g] = -1; issued[g] = 0; max_out[g] = 0; stalled[g] = 0;
    end
    push_expected();
    @(posedge pclk); #1;
    start = 1'b1;
    acc_ready = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic run_frame(input bit bp, input int extra, input bit timing);
    int rel, settle;
    bit ok;
    begin_frame();
    settle = 0;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge pclk); #1;
      rel = cyc - start_cyc;
      start = (rel == extra);
      acc_ready = bp ? ((rel % 3) == 0) : 1'b1;
      if (done_cnt[0] > 0 && done_cnt[1] > 0) settle++;
      if (settle > 4) begin ok = 1; break; end
    end
    start = 1'b0;
    acc_ready = 1'b1;
    chk("frame_timeout", ok, 1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("xfer_count%0d", g), xfers[g], N);
      chk($sformatf("done_count%0d", g), done_cnt[g], 1);
      chk($sformatf("credit_bound%0d", g), max_out[g] <= 4, 1);
      chk($sformatf("leftover%0d", g), (g == 0) ? q0.size() : q1.size(), 0);
      if (timing) begin
        chk($sformatf("first_acc%0d", g), first_acc[g], 2 + g + 1);
        chk($sformatf("last_xfer%0d", g), last_xfer[g], 2 + g + 1 + N - 1);
        chk($sformatf("done_cycle%0d", g), done_rel[g], 2 + g + 1 + N);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    @(negedge pclk); #1;
    check_all_zero("reset_state");
    @(posedge pclk); #1;
    reset = 1'b1;
    repeat (2) @(posedge pclk);

    run_frame(1'b0, -1, 1'b1);
    run_frame(1'b1, -1, 1'b0);
    run_frame(1'b0, 5, 1'b1);

    // abort a frame with reset in cycle 6, then read a clean frame
    begin_frame();
    for (int k = 0; k < 6; k++) begin
      @(posedge pclk); #1;
      start = 1'b0;
    end
    reset = 1'b0;
    @(negedge pclk); #1;
    check_all_zero("mid_reset");
    q0.delete();
    q1.delete();
    repeat (2) @(posedge pclk);
    #1 reset = 1'b1;
    repeat (2) @(posedge pclk);
    run_frame(1'b0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bgsub_frame_reader.md
# bgsub_frame_reader

Streams pixel pairs into the background-subtraction datapath. On a start pulse it sweeps one frame's address range over the current-frame and reference-frame memories in lockstep. It absorbs the fixed memory read latency and delivers 5-bit current/reference pixel pairs with a valid/ready handshake onto the subtractor/accumulator inputs (`current_frame`, `reference_frame`, `acc_en`). It is the read side of the frame buffers that the capture logic writes.

## Interface
- `FRAME_W`, 160: pixels per line, even, ≥2.
- `FRAME_H`, 120: lines per frame, even, ≥2.
- `ADDR_W`, 15: memory address width; must satisfy FRAME_W*FRAME_H ≤ 2^ADDR_W.
- `MEM_LAT`, 1: memory read latency in cycles, 1 or 2.
- `pclk`  in  1  pixel clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to read one frame; ignored while `busy`=1.
- `rd_addr`  out  ADDR_W  shared read address to both frame memories.
- `rd_en`  out  1  read strobe; each strobe returns data MEM_LAT cycles later.
- `cur_data`  in  5  current-frame memory read data.
- `ref_data`  in  5  reference-frame memory read data.
- `current_frame`  out  5  current pixel toward the subtractor.
- `reference_frame`  out  5  reference pixel toward the subtractor.
- `acc_en`  out  1  output pair valid.
- `acc_ready`  in  1  downstream accepts; a transfer occurs when `acc_en` and `acc_ready` are both 1.
- `line_end`  out  1  qualifies the current pair as the last pixel of a line; meaningful only with `acc_en`.
- `frame_end`  out  1  qualifies the current pair as the last pixel of the frame.
- `busy`  out  1  a frame read is in progress.
- `frame_done`  out  1  one-cycle pulse after the final transfer.

## Operation
- Reset values: `rd_addr`=0, `rd_en`=0, all data outputs 0, `acc_en`/`line_end`/`frame_end`/`busy`/`frame_done`=0. The FSM resets to IDLE. The FIFO and in-flight count are cleared.
- FSM:
  - IDLE: `start` moves to READ with the column/line counters at 0.
  - READ: issues reads. On issue of the last address, moves to DRAIN.
  - DRAIN: when the FIFO is empty and in-flight=0, moves to DONE.
  - DONE: asserts `frame_done` for one cycle, then returns to IDLE.
- Address: `rd_addr` = line*FRAME_W + column, computed by increment, not multiplication. The column wraps at FRAME_W-1 and the line increments. The last address is FRAME_W*FRAME_H-1.
- Return path: a 4-entry FIFO of {cur, ref, line_end, frame_end}, 12 bits wide. The tags are computed at issue and delayed MEM_LAT cycles with the read.
- Credit: `rd_en` may assert only if FIFO count + in-flight reads < 4 after accounting for a same-cycle pop. The FIFO never overflows.
- Output: `acc_en` = FIFO not empty. The outputs are driven from the FIFO head and stay stable while `acc_en`=1 and `acc_ready`=0.
- Simultaneous push and pop: the count is unchanged.
- `start` while `busy`=1 is dropped and not queued.
- `reset` asserted mid-frame clears everything immediately. Read data returning after reset is ignored.

## Timing
- `start` high in cycle 0 → `busy`=1, `rd_en`=1, `rd_addr`=0 in cycle 1.
- Read data is valid on `cur_data`/`ref_data` in cycle 1+MEM_LAT and is pushed at the end of that cycle.
- The first `acc_en` is in cycle 2+MEM_LAT.
- With `acc_ready` held at 1, throughput is one pair per cycle with no bubbles for MEM_LAT ≤ 2.
- `frame_done` pulses in the cycle after the transfer carrying `frame_end`. `busy` falls in the same cycle as that pulse.
- The earliest re-start is the cycle after `frame_done`.

## Configuration
- `BGSUB_DECIMATE_EN` defined:
  - Half-resolution sweep: only even columns of even lines are read.
  - The address steps by 2 and odd lines are skipped.
  - A frame is (FRAME_W/2)*(FRAME_H/2) pairs.
  - `line_end` marks column FRAME_W-2.
  - The last address is (FRAME_H-2)*FRAME_W + FRAME_W-2.
- Undefined: the full-resolution sweep described above.

## Test plan
- Full frame, no backpressure:
  - Stimulus: FRAME_W=4, FRAME_H=2, MEM_LAT=1; memories hold cur=addr, ref=31-addr; `start` in cycle 0, `acc_ready`=1.
  - Required: 8 consecutive pairs (0,31)…(7,24) in cycles 3–10; `line_end` on pairs 3 and 7; `frame_end` on pair 7; `frame_done` in cycle 11.
- Backpressure:
  - Stimulus: same setup with `acc_ready` toggled 1,0,0,1,…
  - Required: the same 8 pairs in order, none lost or duplicated; outputs stable while stalled; in-flight reads never exceed the free FIFO slots.
- MEM_LAT=2:
  - Stimulus: setup as in the first scenario.
  - Required: first `acc_en` in cycle 4; 8 pairs back-to-back.
- Start and reset handling:
  - Stimulus: second `start` pulse in cycle 5.
  - Required: ignored; exactly 8 transfers, one `frame_done`.
  - Stimulus: `reset` low in cycle 6 of a frame.
  - Required: all outputs 0 immediately; a new `start` yields a clean frame from addr 0.
- `BGSUB_DECIMATE_EN`:
  - Stimulus: FRAME_W=4, FRAME_H=4.
  - Required: `rd_addr` sequence 0,2,8,10; `line_end` on pairs 1 and 3; `frame_end` on pair 3.
